// File: rtl/sdram_req_queue.sv
// Command FIFO and request pacer in front of sdram_ctrl; holds requests until the init window elapses.
// Define SDRAM_REQ_STATS_EN to add saturating issued-write/read counters (o_wr_count, o_rd_count).
module sdram_req_queue #(
   parameter int unsigned AddrWidth  = 22,
   parameter int unsigned DataWidth  = 16,
   parameter int unsigned Depth      = 4,
   parameter int unsigned InitCycles = 26600,
   parameter int unsigned ReqGap     = 40,
   parameter int unsigned RdLatency  = 12
) (
   input  logic                 i_sys_clk,
   input  logic                 i_rst_n,
   input  logic                 i_cmd_valid,
   output logic                 o_cmd_ready,
   input  logic                 i_cmd_we,
   input  logic [AddrWidth-1:0] i_cmd_addr,
   input  logic [DataWidth-1:0] i_cmd_wdata,
   output logic                 o_rsp_valid,
   output logic [DataWidth-1:0] o_rsp_data,
   output logic                 o_init_done,
   output logic                 o_busy,
   output logic                 o_wr_req,
   output logic [AddrWidth-1:0] o_wr_addr,
   output logic [DataWidth-1:0] o_wr_data,
   output logic                 o_rd_req,
   output logic [AddrWidth-1:0] o_rd_addr,
   input  logic [DataWidth-1:0] i_rd_data
`ifdef SDRAM_REQ_STATS_EN
   ,
   output logic [15:0]          o_wr_count,
   output logic [15:0]          o_rd_count
`endif
);

   localparam int unsigned PtrW   = $clog2(Depth);
   localparam int unsigned CntW   = PtrW + 1;
   localparam int unsigned InitW  = $clog2(InitCycles + 1);
   localparam int unsigned TmrW   = $clog2(ReqGap);
   localparam int unsigned EntryW = 1 + AddrWidth + DataWidth;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ISSUE, ST_GAP} state_t;

   state_t           state_q, state_d;
   logic [InitW-1:0] init_cnt_q, init_cnt_d;
   logic [TmrW-1:0]  tmr_q, tmr_d;
   logic             init_done_d;
   logic             pop;

   logic [EntryW-1:0]    mem [Depth];
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]      count_q, count_d;
   logic                 push;
   logic                 rd_pend_q;
   logic                 capture;
   logic [EntryW-1:0]    head;
   logic                 head_we;
   logic [AddrWidth-1:0] head_addr;
   logic [DataWidth-1:0] head_data;

   assign push      = i_cmd_valid && o_cmd_ready;
   assign count_d   = count_q + CntW'(push) - CntW'(pop);
   assign head      = mem[rd_ptr_q];
   assign head_we   = head[EntryW-1];
   assign head_addr = head[AddrWidth+DataWidth-1:DataWidth];
   assign head_data = head[DataWidth-1:0];
   // Read data is due RdLatency edges after the rising edge of o_rd_req; tmr_q counts edges since then.
   assign capture   = rd_pend_q && (tmr_q == TmrW'(RdLatency - 1))
                      && ((state_q == ST_ISSUE) || (state_q == ST_GAP));

   // State register
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         tmr_q       <= '0;
         o_init_done <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         tmr_q       <= tmr_d;
         o_init_done <= init_done_d;
      end
   end

   // Next-state: the GAP exit is timed so the next pop lands exactly ReqGap edges after the last one
   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      tmr_d       = tmr_q;
      init_done_d = o_init_done;
      pop         = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (init_cnt_q == InitW'(InitCycles - 1)) begin
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end else begin
               init_cnt_d = init_cnt_q + InitW'(1);
            end
         end
         ST_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = ST_ISSUE;
               tmr_d   = '0;
            end
         end
         ST_ISSUE, ST_GAP: begin
            if (tmr_q == TmrW'(ReqGap - 2)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_GAP;
               tmr_d   = tmr_q + TmrW'(1);
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // FIFO storage; no reset needed since only entries below count are ever read
   always_ff @(posedge i_sys_clk) begin
      if (push) mem[wr_ptr_q] <= {i_cmd_we, i_cmd_addr, i_cmd_wdata};
   end

   // Pointers, flags, controller requests and read response
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         o_cmd_ready <= 1'b1;
         o_busy      <= 1'b1;
         o_wr_req    <= 1'b0;
         o_rd_req    <= 1'b0;
         o_wr_addr   <= '0;
         o_wr_data   <= '0;
         o_rd_addr   <= '0;
         rd_pend_q   <= 1'b0;
         o_rsp_valid <= 1'b0;
         o_rsp_data  <= '0;
      end else begin
         count_q     <= count_d;
         o_cmd_ready <= (count_d != CntW'(Depth));
         o_busy      <= (state_d != ST_IDLE) || (count_d != '0);
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         o_wr_req    <= 1'b0;
         o_rd_req    <= 1'b0;
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (head_we) begin
               o_wr_req  <= 1'b1;
               o_wr_addr <= head_addr;
               o_wr_data <= head_data;
            end else begin
               o_rd_req  <= 1'b1;
               o_rd_addr <= head_addr;
               rd_pend_q <= 1'b1;
            end
         end
         o_rsp_valid <= capture;
         if (capture) begin
            o_rsp_data <= i_rd_data;
            rd_pend_q  <= 1'b0;
         end
      end
   end

`ifdef SDRAM_REQ_STATS_EN
   // Issued request counters, saturating
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wr_count <= '0;
         o_rd_count <= '0;
      end else if (pop) begin
         if (head_we && (o_wr_count != 16'hFFFF)) o_wr_count <= o_wr_count + 16'd1;
         if (!head_we && (o_rd_count != 16'hFFFF)) o_rd_count <= o_rd_count + 16'd1;
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_sdram_req_queue.sv
// Bench for sdram_req_queue: cycle-level model of the queue/pacing rules, a controller read-data model,
// and directed scenarios with hand-computed expectations.
module tb_sdram_req_queue;
   localparam int AW    = 22;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int INIT  = 100;
   localparam int GAP   = 8;
   localparam int RDLAT = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_we = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          init_done;
   logic          busy;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data = 16'h5A5A;
`ifdef SDRAM_REQ_STATS_EN
   logic [15:0]   wr_count;
   logic [15:0]   rd_count;
`endif

   sdram_req_queue #(
      .AddrWidth(AW), .DataWidth(DW), .Depth(DEPTH),
      .InitCycles(INIT), .ReqGap(GAP), .RdLatency(RDLAT)
   ) dut (
      .i_sys_clk(clk), .i_rst_n(rst_n),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
      .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
      .o_init_done(init_done), .o_busy(busy),
      .o_wr_req(wr_req), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
      .o_rd_req(rd_req), .o_rd_addr(rd_addr), .i_rd_data(rd_data)
`ifdef SDRAM_REQ_STATS_EN
      , .o_wr_count(wr_count), .o_rd_count(rd_count)
`endif
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
   cmd_t m_q[$];
   int   m_cyc = 0;
   int   m_last_rise = -1000;
   int   m_rd_rise = -1000;
   int   m_wr_cnt = 0;
   int   m_rd_cnt = 0;
   logic          e_ready = 1'b1, e_busy = 1'b1, e_init = 1'b0;
   logic          e_wr_req = 1'b0, e_rd_req = 1'b0, e_rsp_valid = 1'b0;
   logic [AW-1:0] e_wr_addr = '0, e_rd_addr = '0;
   logic [DW-1:0] e_wr_data = '0, e_rsp_data = '0;

   task automatic model_reset();
      m_q.delete();
      m_cyc = 0; m_last_rise = -1000; m_rd_rise = -1000; m_wr_cnt = 0; m_rd_cnt = 0;
      e_ready = 1'b1; e_busy = 1'b1; e_init = 1'b0;
      e_wr_req = 1'b0; e_rd_req = 1'b0; e_rsp_valid = 1'b0;
      e_wr_addr = '0; e_rd_addr = '0; e_wr_data = '0; e_rsp_data = '0;
   endtask

   // Edge e: issue needs the init window passed, ReqGap since last issue and a non-empty queue
   task automatic model_step();
      int   e;
      bit   iss, psh;
      cmd_t c;
      e   = m_cyc + 1;
      iss = (e > INIT) && (e >= m_last_rise + GAP) && (m_q.size() > 0);
      psh = cmd_valid && (m_q.size() < DEPTH);
      e_wr_req = 1'b0;
      e_rd_req = 1'b0;
      if (iss) begin
         c = m_q.pop_front();
         m_last_rise = e;
         if (c.we) begin
            e_wr_req = 1'b1; e_wr_addr = c.addr; e_wr_data = c.data;
            if (m_wr_cnt < 65535) m_wr_cnt++;
         end else begin
            e_rd_req = 1'b1; e_rd_addr = c.addr; m_rd_rise = e;
            if (m_rd_cnt < 65535) m_rd_cnt++;
         end
      end
      if (psh) m_q.push_back({cmd_we, cmd_addr, cmd_wdata});
      e_rsp_valid = (e == m_rd_rise + RDLAT);
      if (e_rsp_valid) e_rsp_data = rd_data;
      e_init  = (e >= INIT);
      e_ready = (m_q.size() < DEPTH);
      e_busy  = (e < INIT) || (e - m_last_rise <= GAP - 2) || (m_q.size() > 0);
      m_cyc   = e;
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
   end

   // Per-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("cyc_ready", 32'(cmd_ready), 32'(e_ready));
         chk("cyc_busy", 32'(busy), 32'(e_busy));
         chk("cyc_init_done", 32'(init_done), 32'(e_init));
         chk("cyc_wr_req", 32'(wr_req), 32'(e_wr_req));
         chk("cyc_rd_req", 32'(rd_req), 32'(e_rd_req));
         chk("cyc_wr_addr", 32'(wr_addr), 32'(e_wr_addr));
         chk("cyc_wr_data", 32'(wr_data), 32'(e_wr_data));
         chk("cyc_rd_addr", 32'(rd_addr), 32'(e_rd_addr));
         chk("cyc_rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
         chk("cyc_rsp_data", 32'(rsp_data), 32'(e_rsp_data));
         chk("cyc_req_excl", 32'(wr_req && rd_req), 32'd0);
`ifdef SDRAM_REQ_STATS_EN
         chk("cyc_wr_count", 32'(wr_count), 32'(m_wr_cnt));
         chk("cyc_rd_count", 32'(rd_count), 32'(m_rd_cnt));
`endif
      end
   end

   // ---------------- controller model and event log ----------------
   logic [DW-1:0] ctl_mem [logic [AW-1:0]];
   int            rd_due = -1;
   logic [DW-1:0] rd_val = '0;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         rd_due = -1;
      end else begin
         if (wr_req) ctl_mem[wr_addr] = wr_data;
         if (rd_req) begin
            rd_due = m_cyc + RDLAT;
            rd_val = ctl_mem.exists(rd_addr) ? ctl_mem[rd_addr] : 16'hBEEF;
         end
      end
      rd_data = (rst_n && (m_cyc + 1 == rd_due)) ? rd_val : 16'h5A5A;
   end

   typedef struct { int cyc; bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } ev_t;
   ev_t rises[$];
   ev_t rsps[$];
   int  init_rise = -1;

   initial forever begin
      ev_t ev;
      @(negedge clk);
      if (rst_n) begin
         if (wr_req || rd_req) begin
            ev.cyc = m_cyc; ev.we = wr_req;
            ev.addr = wr_req ? wr_addr : rd_addr;
            ev.data = wr_data;
            rises.push_back(ev);
         end
         if (rsp_valid) begin
            ev.cyc = m_cyc; ev.we = 1'b0; ev.addr = '0; ev.data = rsp_data;
            rsps.push_back(ev);
         end
         if (init_done && init_rise < 0) init_rise = m_cyc;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_logs();
      rises.delete(); rsps.delete(); init_rise = -1;
   endtask

   task automatic wait_cyc(input int n);
      while (m_cyc < n) begin
         @(posedge clk); #1;
      end
   endtask

   // Holds the command on the bus until a handshake edge; leaves valid asserted
   task automatic push(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc);
      logic r;
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
      acc = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); r = cmd_ready;
         @(posedge clk); #1;
         if (r) begin
            acc = m_cyc;
            break;
         end
      end
   endtask

   task automatic wait_rises(input string name, input int n, input int max);
      for (int i = 0; i < max && rises.size() < n; i++) begin
         @(posedge clk); #1;
      end
      chk(name, 32'(rises.size()), 32'(n));
   endtask

   task automatic wait_rsps(input string name, input int n, input int max);
      for (int i = 0; i < max && rsps.size() < n; i++) begin
         @(posedge clk); #1;
      end
      chk(name, 32'(rsps.size()), 32'(n));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_init_done"}, 32'(init_done), 32'd0);
      chk({tag, "_reqs"}, 32'({wr_req, rd_req, rsp_valid}), 32'd0);
      chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
      chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
      chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
   endtask

   task automatic reset_dut();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      clear_logs();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   logic [AW-1:0] s3_addr [5] = '{22'h012345, 22'h012345, 22'h2ABCDE, 22'h2ABCDE, 22'h3FFFFF};
   logic [DW-1:0] s3_data [5] = '{16'hA5A5, 16'h0000, 16'h0F0F, 16'h0000, 16'hFFFF};
   bit            s3_we   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("por");
      cmp_en = 1'b1;
      clear_logs();
      @(negedge clk);
      rst_n = 1'b1;

      // Write held back until init, then read returning controller data
      wait_cyc(9);
      push(1'b1, {2'd0, 8'd5, 12'd13}, 16'h1234, acc);
      cmd_valid = 1'b0;
      chk("s1_accept_cyc", 32'(acc), 32'd10);
      wait_rises("s1_wr_timeout", 1, 300);
      if (rises.size() >= 1) begin
         chk("s1_wr_cyc", 32'(rises[0].cyc), 32'd101);
         chk("s1_wr_kind", 32'(rises[0].we), 32'd1);
         chk("s1_wr_addr", 32'(rises[0].addr), 32'({2'd0, 8'd5, 12'd13}));
         chk("s1_wr_data", 32'(rises[0].data), 32'h1234);
      end
      chk("s1_init_cyc", 32'(init_rise), 32'd100);
      push(1'b0, {2'd0, 8'd10, 12'd53}, 16'h0000, acc);
      cmd_valid = 1'b0;
      wait_rsps("s2_rsp_timeout", 1, 100);
      if (rsps.size() >= 1 && rises.size() >= 2) begin
         chk("s2_rd_addr", 32'(rises[1].addr), 32'({2'd0, 8'd10, 12'd53}));
         chk("s2_rsp_data", 32'(rsps[0].data), 32'hBEEF);
         chk("s2_rsp_latency", 32'(rsps[0].cyc - rises[1].cyc), 32'd5);
      end

      // Five back-to-back pushes during init, alternating W/R
      reset_dut();
      wait_cyc(5);
      for (int i = 0; i < 4; i++) begin
         push(s3_we[i], s3_addr[i], s3_data[i], acc);
         chk("s3_accept_cyc", 32'(acc), 32'(6 + i));
      end
      chk("s3_ready_low", 32'(cmd_ready), 32'd0);
      push(s3_we[4], s3_addr[4], s3_data[4], acc);
      cmd_valid = 1'b0;
      chk("s3_fifth_accept", 32'(acc), 32'd102);
      wait_rises("s3_rise_timeout", 5, 200);
      for (int i = 0; i < 5 && i < rises.size(); i++) begin
         chk("s3_rise_cyc", 32'(rises[i].cyc), 32'(101 + 8 * i));
         chk("s3_rise_kind", 32'(rises[i].we), 32'(s3_we[i]));
         chk("s3_rise_addr", 32'(rises[i].addr), 32'(s3_addr[i]));
      end
      wait_cyc(145);
      chk("s3_rsp_count", 32'(rsps.size()), 32'd2);
      if (rsps.size() >= 2) begin
         chk("s3_rsp0_cyc", 32'(rsps[0].cyc), 32'd114);
         chk("s3_rsp0_data", 32'(rsps[0].data), 32'hA5A5);
         chk("s3_rsp1_cyc", 32'(rsps[1].cyc), 32'd130);
         chk("s3_rsp1_data", 32'(rsps[1].data), 32'h0F0F);
      end
`ifdef SDRAM_REQ_STATS_EN
      chk("s3_wr_count", 32'(wr_count), 32'd3);
      chk("s3_rd_count", 32'(rd_count), 32'd2);
`endif

      // Reset mid-GAP with three commands still queued and a read response pending
      reset_dut();
      wait_cyc(5);
      push(1'b0, 22'h000111, 16'h0000, acc);
      push(1'b1, 22'h000222, 16'h2222, acc);
      push(1'b1, 22'h000333, 16'h3333, acc);
      push(1'b1, 22'h000444, 16'h4444, acc);
      cmd_valid = 1'b0;
      wait_cyc(104);
      chk("s5_pre_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("s5_rst");
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 22'h000555; cmd_wdata = 16'h5555;
      repeat (2) @(posedge clk);
      clear_logs();
      @(negedge clk);
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      wait_cyc(150);
      chk("s5_no_reqs", 32'(rises.size()), 32'd0);
      chk("s5_no_rsp", 32'(rsps.size()), 32'd0);
      chk("s5_init_cyc", 32'(init_rise), 32'd100);

      @(posedge clk); #1;
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
